// File: rtl/mmio_responder_if.sv
// CPU-side I/O port bundle: one-cycle read/write strobes, byte offset, write data, registered read return.
// Latency: one cycle from a read strobe to rdata/rvalid; there is no backpressure.
interface mmio_responder_if;
    logic        io_read;
    logic        io_write;
    logic [9:0]  io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        io_rvalid;

    modport master (
        output io_read, io_write, io_addr, io_wdata,
        input  io_rdata, io_rvalid
    );

    modport slave (
        input  io_read, io_write, io_addr, io_wdata,
        output io_rdata, io_rvalid
    );
endinterface

// File: rtl/mmio_responder.sv
// I/O page responder: LED register, synchronised switches, prescaled one-shot/auto-reload timer.
// Latency: reads return 1 cycle after the strobe; writes land at the end of the strobe cycle; there is no backpressure.
module mmio_responder #(
    parameter int PRESCALE       = 16,
    parameter int SW_SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   resetn,
    mmio_responder_if.slave        io,
    input  logic [23:0]            switch_i,
    output logic [23:0]            led_o,
    output logic                   timer_irq,
    output logic                   bad_addr
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [9:0] A_CTRL   = 10'h020;
    localparam logic [9:0] A_RELOAD = 10'h024;
    localparam logic [9:0] A_COUNT  = 10'h026;
    localparam logic [9:0] A_STATUS = 10'h028;
    localparam logic [9:0] A_LED_LO = 10'h060;
    localparam logic [9:0] A_LED_HI = 10'h062;
    localparam logic [9:0] A_SW_LO  = 10'h070;
    localparam logic [9:0] A_SW_HI  = 10'h072;

    typedef enum logic {T_IDLE, T_RUN} tstate_t;

    tstate_t       state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          expired_q, expired_d;
    logic [15:0]   reload_q;
    logic          auto_reload_q;
    logic          irq_en_q;
    logic [23:0]   led_q;

    logic [SW_SYNC_STAGES-1:0][23:0] sync_q;
    logic [23:0] sw_sync;

    logic        rd, wr, conflict, mapped, running, tick;
    logic        ctrl_wr, status_rd;
    logic [15:0] rd_mux;

    // A simultaneous read and write is illegal: neither side is performed.
    assign conflict  = io.io_read & io.io_write;
    assign rd        = io.io_read & ~io.io_write;
    assign wr        = io.io_write & ~io.io_read;
    assign running   = (state_q == T_RUN);
    assign tick      = running && (presc_q == PRESC_LAST);
    assign ctrl_wr   = wr && (io.io_addr == A_CTRL);
    assign status_rd = rd && (io.io_addr == A_STATUS);
    assign sw_sync   = sync_q[SW_SYNC_STAGES-1];
    assign led_o     = led_q;
    assign timer_irq = expired_q & irq_en_q;

    always_comb begin
        mapped = 1'b1;
        rd_mux = 16'h0000;
        case (io.io_addr)
            A_LED_LO: rd_mux = led_q[15:0];
            A_LED_HI: rd_mux = {8'h00, led_q[23:16]};
            A_SW_LO:  rd_mux = sw_sync[15:0];
            A_SW_HI:  rd_mux = {8'h00, sw_sync[23:16]};
            A_CTRL:   rd_mux = {13'h0000, irq_en_q, auto_reload_q, running};
            A_RELOAD: rd_mux = reload_q;
            A_COUNT:  rd_mux = count_q;
            A_STATUS: rd_mux = {14'h0000, running, expired_q};
            default:  mapped = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= switch_i;
            for (int i = 1; i < SW_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            io.io_rdata   <= 16'h0000;
            io.io_rvalid  <= 1'b0;
            bad_addr      <= 1'b0;
            led_q         <= 24'h000000;
            reload_q      <= 16'h0000;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
        end else begin
            io.io_rvalid <= rd;
            // Unmapped reads fall through the mux as zero, so no special case here.
            if (rd) begin
                io.io_rdata <= rd_mux;
            end
            bad_addr <= conflict | ((rd | wr) & ~mapped);
            if (wr && io.io_addr == A_LED_LO) begin
                led_q[15:0] <= io.io_wdata;
            end
            if (wr && io.io_addr == A_LED_HI) begin
                led_q[23:16] <= io.io_wdata[7:0];
            end
            if (wr && io.io_addr == A_RELOAD) begin
                reload_q <= io.io_wdata;
            end
            if (ctrl_wr) begin
                auto_reload_q <= io.io_wdata[1];
                irq_en_q      <= io.io_wdata[2];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= T_IDLE;
            count_q   <= 16'h0000;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    // A ctrl write overrides any tick in the same cycle; an expiry tick wins over a status-read clear.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        expired_d = expired_q;
        if (status_rd) begin
            expired_d = 1'b0;
        end
        if (ctrl_wr) begin
            if (io.io_wdata[0]) begin
                state_d = T_RUN;
                count_d = reload_q;
                presc_d = '0;
            end else begin
                state_d = T_IDLE;
            end
        end else begin
            case (state_q)
                T_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        if (count_q != 16'h0000) begin
                            count_d = count_q - 16'd1;
                        end else begin
                            expired_d = 1'b1;
                            if (auto_reload_q) begin
                                count_d = reload_q;
                            end else begin
                                state_d = T_IDLE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: vector table, timer corner sequences, randomised register traffic.
`timescale 1ns/1ps
module tb_mmio_responder;
    localparam int PRESCALE  = 4;
    localparam int SW_STAGES = 2;
    localparam int NVEC      = 14;
    localparam int NRAND     = 400;

    logic        clock    = 1'b0;
    logic        resetn   = 1'b0;
    logic [23:0] switch_i = 24'h000000;
    logic [23:0] led_o;
    logic        timer_irq;
    logic        bad_addr;

    mmio_responder_if bus ();

    mmio_responder #(
        .PRESCALE       (PRESCALE),
        .SW_SYNC_STAGES (SW_STAGES)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .io        (bus),
        .switch_i  (switch_i),
        .led_o     (led_o),
        .timer_irq (timer_irq),
        .bad_addr  (bad_addr)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        rvalid;
        logic        bad;
        logic [23:0] led;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [9:0] a, input logic [15:0] d);
        bus.io_read  = rd;
        bus.io_write = wr;
        bus.io_addr  = a;
        bus.io_wdata = d;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [9:0] a, input logic [15:0] d);
        drive(rd, wr, a, d);
        step();
        drive(1'b0, 1'b0, 10'h000, 16'h0000);
    endtask

    task automatic rd_chk(input string name, input logic [9:0] a, input logic [15:0] exp);
        access(1'b1, 1'b0, a, 16'h0000);
        check({name, " rvalid"}, 32'(bus.io_rvalid), 32'd1);
        check({name, " rdata"}, 32'(bus.io_rdata), 32'(exp));
    endtask

    task automatic wait_to(input int base, input int n);
        if (cyc > base + n) begin
            errors++;
            $display("FAIL schedule: at cycle %0d, already past target %0d", cyc - base, n);
        end
        while (cyc < base + n) step();
    endtask

    function automatic logic is_mapped(input logic [9:0] a);
        return a == 10'h020 || a == 10'h024 || a == 10'h026 || a == 10'h028 ||
               a == 10'h060 || a == 10'h062 || a == 10'h070 || a == 10'h072;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [23:0] m_led;
        logic [15:0] m_reload;
        logic [15:0] m_rdata;
        logic [23:0] swq [$];

        vecs[0]  = '{1'b0, 1'b1, 10'h060, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 24'h00A5A5};
        vecs[1]  = '{1'b0, 1'b1, 10'h062, 16'hFF3C, 16'h0000, 1'b0, 1'b0, 24'h3CA5A5};
        vecs[2]  = '{1'b1, 1'b0, 10'h062, 16'h0000, 16'h003C, 1'b1, 1'b0, 24'h3CA5A5};
        vecs[3]  = '{1'b1, 1'b0, 10'h060, 16'h0000, 16'hA5A5, 1'b1, 1'b0, 24'h3CA5A5};
        vecs[4]  = '{1'b1, 1'b1, 10'h060, 16'h1234, 16'hA5A5, 1'b0, 1'b1, 24'h3CA5A5};
        vecs[5]  = '{1'b1, 1'b0, 10'h3FC, 16'h0000, 16'h0000, 1'b1, 1'b1, 24'h3CA5A5};
        vecs[6]  = '{1'b0, 1'b1, 10'h3FC, 16'h5555, 16'h0000, 1'b0, 1'b1, 24'h3CA5A5};
        vecs[7]  = '{1'b0, 1'b1, 10'h070, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 24'h3CA5A5};
        vecs[8]  = '{1'b0, 1'b1, 10'h024, 16'h0007, 16'h0000, 1'b0, 1'b0, 24'h3CA5A5};
        vecs[9]  = '{1'b1, 1'b0, 10'h024, 16'h0000, 16'h0007, 1'b1, 1'b0, 24'h3CA5A5};
        vecs[10] = '{1'b0, 1'b1, 10'h026, 16'hFFFF, 16'h0007, 1'b0, 1'b0, 24'h3CA5A5};
        vecs[11] = '{1'b1, 1'b0, 10'h026, 16'h0000, 16'h0000, 1'b1, 1'b0, 24'h3CA5A5};
        vecs[12] = '{1'b1, 1'b0, 10'h020, 16'h0000, 16'h0000, 1'b1, 1'b0, 24'h3CA5A5};
        vecs[13] = '{1'b1, 1'b0, 10'h061, 16'h0000, 16'h0000, 1'b1, 1'b1, 24'h3CA5A5};

        drive(1'b0, 1'b0, 10'h000, 16'h0000);
        repeat (3) step();
        check("reset rdata", 32'(bus.io_rdata), 32'h0);
        check("reset rvalid", 32'(bus.io_rvalid), 32'h0);
        check("reset led", 32'(led_o), 32'h0);
        check("reset irq", 32'(timer_irq), 32'h0);
        check("reset bad", 32'(bad_addr), 32'h0);
        resetn = 1'b1;
        step();

        for (int i = 0; i < NVEC; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d rvalid", i), 32'(bus.io_rvalid), 32'(vecs[i].rvalid));
            check($sformatf("vec%0d rdata", i), 32'(bus.io_rdata), 32'(vecs[i].rdata));
            check($sformatf("vec%0d bad", i), 32'(bad_addr), 32'(vecs[i].bad));
            check($sformatf("vec%0d led", i), 32'(led_o), 32'(vecs[i].led));
            step();
            check($sformatf("vec%0d pulse end", i), 32'({bus.io_rvalid, bad_addr}), 32'h0);
        end

        switch_i = 24'h123456;
        rd_chk("sw early", 10'h070, 16'h0000);
        repeat (3) step();
        rd_chk("sw lo", 10'h070, 16'h3456);
        rd_chk("sw hi", 10'h072, 16'h0012);

        access(1'b0, 1'b1, 10'h024, 16'h0002);
        access(1'b0, 1'b1, 10'h020, 16'h0005);
        base = cyc;
        wait_to(base, 11);
        check("oneshot irq early", 32'(timer_irq), 32'h0);
        wait_to(base, 12);
        check("oneshot irq", 32'(timer_irq), 32'h1);
        rd_chk("oneshot status", 10'h028, 16'h0001);
        check("oneshot irq cleared", 32'(timer_irq), 32'h0);
        rd_chk("oneshot count", 10'h026, 16'h0000);
        rd_chk("oneshot ctrl", 10'h020, 16'h0004);
        rd_chk("oneshot status2", 10'h028, 16'h0000);

        access(1'b0, 1'b1, 10'h024, 16'h0001);
        access(1'b0, 1'b1, 10'h020, 16'h0003);
        base = cyc;
        wait_to(base, 1);
        rd_chk("auto cnt a", 10'h026, 16'h0001);
        access(1'b0, 1'b1, 10'h026, 16'hFFFF);
        check("ro write bad", 32'(bad_addr), 32'h0);
        wait_to(base, 5);
        rd_chk("auto cnt b", 10'h026, 16'h0000);
        wait_to(base, 9);
        check("irq masked", 32'(timer_irq), 32'h0);
        rd_chk("auto cnt c", 10'h026, 16'h0001);
        rd_chk("auto status", 10'h028, 16'h0003);
        wait_to(base, 13);
        rd_chk("auto cnt d", 10'h026, 16'h0000);
        wait_to(base, 15);
        rd_chk("status on tick", 10'h028, 16'h0002);
        rd_chk("flag kept", 10'h028, 16'h0003);
        access(1'b0, 1'b1, 10'h020, 16'h0000);
        rd_chk("stopped status", 10'h028, 16'h0000);

        access(1'b0, 1'b1, 10'h024, 16'hFFFF);
        access(1'b0, 1'b1, 10'h020, 16'h0001);
        repeat (20) step();
        rd_chk("pre-reset status", 10'h028, 16'h0002);
        resetn = 1'b0;
        step();
        check("midreset irq", 32'(timer_irq), 32'h0);
        check("midreset led", 32'(led_o), 32'h0);
        resetn = 1'b1;
        step();
        rd_chk("midreset count", 10'h026, 16'h0000);
        rd_chk("midreset status", 10'h028, 16'h0000);
        rd_chk("midreset led lo", 10'h060, 16'h0000);

        // Randomised traffic against a register-level model; the switch path is a fixed-lag queue.
        switch_i = 24'h5A5A5A;
        repeat (3) step();
        swq.delete();
        swq.push_back(24'h5A5A5A);
        swq.push_back(24'h5A5A5A);
        m_led    = 24'h000000;
        m_reload = 16'h0000;
        m_rdata  = 16'h0000;

        for (int k = 0; k < NRAND; k++) begin
            int          op;
            logic [15:0] d;
            logic [9:0]  a;
            logic [23:0] sw;
            logic [23:0] sync_v;
            logic        e_rv;
            logic        e_bad;
            logic        rd;
            logic        wr;

            op     = int'($urandom_range(0, 8));
            d      = 16'($urandom);
            sw     = 24'($urandom);
            a      = 10'h000;
            e_rv   = 1'b0;
            e_bad  = 1'b0;
            rd     = 1'b0;
            wr     = 1'b0;
            swq.push_back(sw);
            sync_v = swq[0];
            void'(swq.pop_front());

            case (op)
                0: begin wr = 1'b1; a = 10'h060; m_led[15:0] = d; end
                1: begin wr = 1'b1; a = 10'h062; m_led[23:16] = d[7:0]; end
                2: begin wr = 1'b1; a = 10'h024; m_reload = d; end
                3: begin
                    rd = 1'b1;
                    e_rv = 1'b1;
                    case ($urandom_range(0, 4))
                        0: begin a = 10'h060; m_rdata = m_led[15:0]; end
                        1: begin a = 10'h062; m_rdata = {8'h00, m_led[23:16]}; end
                        2: begin a = 10'h024; m_rdata = m_reload; end
                        3: begin a = 10'h070; m_rdata = sync_v[15:0]; end
                        default: begin a = 10'h072; m_rdata = {8'h00, sync_v[23:16]}; end
                    endcase
                end
                4, 5: begin
                    a = 10'($urandom);
                    if (is_mapped(a)) a = 10'h3FC;
                    e_bad = 1'b1;
                    if (op == 4) begin
                        rd = 1'b1;
                        e_rv = 1'b1;
                        m_rdata = 16'h0000;
                    end else begin
                        wr = 1'b1;
                    end
                end
                6: begin
                    rd = 1'b1;
                    wr = 1'b1;
                    a = ($urandom_range(0, 1) == 0) ? 10'h060 : 10'h024;
                    e_bad = 1'b1;
                end
                7: begin wr = 1'b1; a = ($urandom_range(0, 1) == 0) ? 10'h070 : 10'h072; end
                default: ;
            endcase

            switch_i = sw;
            access(rd, wr, a, d);
            check($sformatf("rnd%0d rvalid", k), 32'(bus.io_rvalid), 32'(e_rv));
            check($sformatf("rnd%0d rdata", k), 32'(bus.io_rdata), 32'(m_rdata));
            check($sformatf("rnd%0d bad", k), 32'(bad_addr), 32'(e_bad));
            check($sformatf("rnd%0d led", k), 32'(led_o), 32'(m_led));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder at the far end of the CPU's I/O port.
- The control unit asserts io_read/io_write when ALU address bits [31:10] are all 1, i.e. address 0xFFFFFC00-0xFFFFFFFF. This block decodes address bits [9:0] and serves the peripherals behind them.
- Peripherals: a 24-bit LED register, a synchronised 24-bit switch input and one 16-bit prescaled timer with sticky expiry flag and interrupt.
- Read data is registered and returned one cycle after the request.

Parameters:
- PRESCALE, 16, clock cycles per timer decrement (≥1).
- SW_SYNC_STAGES, 2, synchroniser depth on switch_i (≥2).

Ports:
- clock  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- io_read  input  1  I/O read strobe from the control unit, one cycle per access.
- io_write  input  1  I/O write strobe from the control unit, one cycle per access.
- io_addr  input  10  byte offset within the I/O page (ALU result [9:0]).
- io_wdata  input  16  write data.
- io_rdata  output  16  registered read data.
- io_rvalid  output  1  pulses high with io_rdata, one cycle after io_read.
- switch_i  input  24  asynchronous board switches.
- led_o  output  24  LED drive.
- timer_irq  output  1  level interrupt, equal to expired AND irq_en.
- bad_addr  output  1  one-cycle pulse on an unmapped or illegal access.

Behaviour:
- Reset (asynchronous, resetn=0): all outputs 0, all registers 0, prescaler 0, timer idle. Synchroniser flops also clear.
- Register map (offset; access; contents):
  - 0x060 RW: led[15:0].
  - 0x062 RW: led[23:16] in bits [7:0]; upper bits read 0, writes to them ignored.
  - 0x070 RO: switch_sync[15:0].
  - 0x072 RO: switch_sync[23:16] in bits [7:0].
  - 0x020 RW: ctrl. bit0 enable, bit1 auto_reload, bit2 irq_en.
  - 0x024 RW: reload[15:0].
  - 0x026 RO: count[15:0].
  - 0x028 RO: status. bit0 expired (sticky, clear-on-read), bit1 running.
- Writes take effect at the end of the strobe cycle. Writes to RO offsets are ignored and do not assert bad_addr.
- Read: the value is sampled on the strobe cycle, then io_rdata/io_rvalid are driven on the next cycle. io_rdata holds its value until the next read. Unmapped read returns 0x0000 with io_rvalid=1 and bad_addr=1.
- io_read and io_write high together: neither is performed, io_rvalid stays 0, bad_addr pulses.
- Unmapped write: ignored, bad_addr pulses.
- Timer:
  - Idle → Running on a ctrl write with bit0=1: count←reload, prescaler←0, running←1.
  - Writing ctrl bit0=1 while already running restarts the same way.
  - Writing ctrl bit0=0 → Idle; count is frozen and expired is unchanged.
  - While running, the prescaler counts 0..PRESCALE-1. At PRESCALE-1 a tick occurs and the prescaler wraps to 0.
  - On a tick with count≠0: count←count-1.
  - On a tick with count==0: expired←1. If auto_reload, count←reload and the timer keeps running. Otherwise running←0 and ctrl.bit0←0.
  - reload=0 therefore expires on the first tick.
  - A reload write while running affects only the next reload or restart.
- Status read clears expired. If an expiry tick coincides with the read, the read returns the pre-tick value and expired ends at 1 (set wins).
- timer_irq is combinational from registered expired AND irq_en. Clearing irq_en masks the interrupt without clearing expired.
- Switch path: SW_SYNC_STAGES-flop synchroniser. A read returns the synchronised value, so it lags switch_i by SW_SYNC_STAGES cycles.
- Reset asserted mid-count: the timer returns to idle immediately, with no expiry and no irq.

Test Plan:
- Reset and LED:
  - Hold resetn=0 → all outputs 0.
  - Release, write 0x060=0xA5A5 and 0x062=0xFF3C → led_o=0x3CA5A5.
  - Read 0x062 → io_rvalid one cycle later with io_rdata=0x003C.
- Switch sync: switch_i=0x123456, then read 0x070 at once and again after 3 cycles.
  - First read returns 0 (pre-sync value).
  - Second read returns 0x3456; read of 0x072 returns 0x0012.
- One-shot timer with PRESCALE=4: reload=2, ctrl=0x5.
  - expired=1 and timer_irq=1 exactly 12 cycles after the ctrl write (3 ticks).
  - Status read returns 0x0001, then expired clears and timer_irq falls.
  - count=0, running=0.
- Auto-reload: reload=1, ctrl=0x3.
  - expired sets every 8 cycles; count sequence 1,0,1,0.
  - Status read landing on an expiry tick → returns bit0=0, flag remains 1.
- Errors:
  - Read 0x3FC → io_rdata=0, bad_addr pulse.
  - io_read=io_write=1 at 0x060 → LED unchanged, io_rvalid=0, bad_addr pulse.
  - Write 0x026 → count unchanged, no bad_addr.
- Reset mid-count: ctrl=0x1, reload=0xFFFF, pull resetn low for 1 cycle → count=0, running=0, timer_irq=0.
